// File: rtl/cordic_ctrl_if.sv
// Request/result handshake bundle between the command front end and cordic_ctrl.
interface cordic_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  select;
    logic [15:0] angle_in;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [15:0] cordic_out;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic        busy;

    modport master (
        output in_valid, select, angle_in, x_in, y_in, out_ready,
        input  in_ready, cordic_out, out_valid, err, busy
    );

    modport slave (
        input  in_valid, select, angle_in, x_in, y_in, out_ready,
        output in_ready, cordic_out, out_valid, err, busy
    );
endinterface

// File: rtl/cordic_ctrl.sv
// Iterative 16-bit CORDIC sequencer: load, ITER micro-rotations, gain/select, hold result.
// Define CORDIC_VECTOR_EN to enable vectoring mode on select[3] (atan(y/x)).
module cordic_ctrl #(
    parameter int unsigned ITER = 16,
    parameter logic [15:0] K    = 16'd155
) (
    input  logic         clk,
    input  logic         rst_n,
    cordic_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_e;
    typedef enum logic [1:0] {OP_SIN, OP_COS, OP_VEC, OP_BAD} op_e;

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [3:0]         i_q, i_d;
    logic signed [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [15:0]        out_q, out_d;
    logic               err_q, err_d;
    logic               in_ready_q, out_valid_q, busy_q;

    function automatic logic signed [15:0] atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'sd6434;
            4'd1:    return 16'sd3798;
            4'd2:    return 16'sd2007;
            4'd3:    return 16'sd1019;
            4'd4:    return 16'sd511;
            4'd5:    return 16'sd256;
            4'd6:    return 16'sd128;
            4'd7:    return 16'sd64;
            4'd8:    return 16'sd32;
            4'd9:    return 16'sd16;
            4'd10:   return 16'sd8;
            4'd11:   return 16'sd4;
            4'd12:   return 16'sd2;
            4'd13:   return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    // Lowest set bit wins; tan (bit2) and an empty select are unsupported.
    function automatic op_e decode(input logic [3:0] sel);
        if (sel[0])      return OP_SIN;
        else if (sel[1]) return OP_COS;
        else if (sel[2]) return OP_BAD;
`ifdef CORDIC_VECTOR_EN
        else if (sel[3]) return OP_VEC;
`endif
        else             return OP_BAD;
    endfunction

    logic signed [15:0] xs, ys, scale_src;
    logic signed [31:0] prod;
    logic               dpos;

    assign xs        = x_q >>> i_q;
    assign ys        = y_q >>> i_q;
    assign scale_src = (op_q == OP_SIN) ? y_q : x_q;
    assign prod      = $signed({{16{scale_src[15]}}, scale_src}) * $signed({16'd0, K});

`ifdef CORDIC_VECTOR_EN
    // Vectoring drives y toward zero; rotation drives z toward zero.
    assign dpos = (op_q == OP_VEC) ? y_q[15] : ~z_q[15];
`else
    assign dpos = ~z_q[15];
    logic unused_vec;
    assign unused_vec = ^{bus.x_in, bus.y_in};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    op_d    = decode(bus.select);
                    i_d     = 4'd0;
                    x_d     = 16'sd16384;
                    y_d     = '0;
                    z_d     = bus.angle_in;
`ifdef CORDIC_VECTOR_EN
                    if (op_d == OP_VEC) begin
                        x_d = bus.x_in;
                        y_d = bus.y_in;
                        z_d = '0;
                    end
`endif
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (op_q == OP_BAD) begin
                    out_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    x_d = dpos ? x_q - ys : x_q + ys;
                    y_d = dpos ? y_q + xs : y_q - xs;
                    z_d = dpos ? z_q - atan_rom(i_q) : z_q + atan_rom(i_q);
                    i_d = i_q + 4'd1;
                    if (i_q == LAST) state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                err_d   = 1'b0;
                out_d   = (op_q == OP_VEC) ? z_q : 16'(prod >>> 8);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_BAD;
            i_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            i_q         <= i_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            out_q       <= out_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.cordic_out = out_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed bench for cordic_ctrl: reset, sin/cos/angle results, unsupported ops,
// output back-pressure and mid-iteration reset.
module tb_cordic_ctrl;
    localparam int ITER = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cordic_ctrl_if bus ();

    cordic_ctrl #(.ITER(ITER), .K(16'd155)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic send(input logic [3:0] sel, input logic [15:0] ang,
                        input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.select   = sel;
        bus.angle_in = ang;
        bus.x_in     = x;
        bus.y_in     = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 40);
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int          lat;
        logic [15:0] held;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.select    = 4'd0;
        bus.angle_in  = 16'd0;
        bus.x_in      = 16'd0;
        bus.y_in      = 16'd0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out", 32'(bus.cordic_out), 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 32'(bus.in_ready), 1);

        // sin(0): bit-exact walk gives y=3 before gain, i.e. 1 after scaling
        send(4'b0001, 16'd0, 16'd0, 16'd0);
        wait_out(lat);
        chk("sin0_lat", 32'(lat), ITER + 1);
        chk_rng("sin0_out", int'($signed(bus.cordic_out)), -2, 2);
        chk("sin0_err", 32'(bus.err), 0);
        chk("sin0_busy", 32'(bus.busy), 1);
        take("sin0");

        // pi/6: final magnitude 16384*1.6468*155/256 ~= 16336 -> cos ~14147, sin ~8168
        send(4'b0010, 16'd4289, 16'd0, 16'd0);
        wait_out(lat);
        chk("cos30_lat", 32'(lat), ITER + 1);
        chk_rng("cos30_out", int'($signed(bus.cordic_out)), 14148 - 32, 14148 + 32);
        chk("cos30_err", 32'(bus.err), 0);
        take("cos30");

        send(4'b0001, 16'd4289, 16'd0, 16'd0);
        wait_out(lat);
        chk_rng("sin30_out", int'($signed(bus.cordic_out)), 8168 - 32, 8168 + 32);
        take("sin30");

        // bit1 outranks bit2: cos
        send(4'b0110, 16'd4289, 16'd0, 16'd0);
        wait_out(lat);
        chk_rng("prio_cos_out", int'($signed(bus.cordic_out)), 14148 - 32, 14148 + 32);
        chk("prio_cos_err", 32'(bus.err), 0);
        take("prio");

        send(4'b0100, 16'd4289, 16'd0, 16'd0);
        wait_out(lat);
        chk("tan_lat", 32'(lat), 1);
        chk("tan_out", 32'(bus.cordic_out), 0);
        chk("tan_err", 32'(bus.err), 1);
        take("tan");

        send(4'b0000, 16'd4289, 16'd0, 16'd0);
        wait_out(lat);
        chk("none_lat", 32'(lat), 1);
        chk("none_out", 32'(bus.cordic_out), 0);
        chk("none_err", 32'(bus.err), 1);
        take("none");

        send(4'b1000, 16'd0, 16'd8192, 16'd8192);
        wait_out(lat);
`ifdef CORDIC_VECTOR_EN
        chk("vec_lat", 32'(lat), ITER + 1);
        chk_rng("vec_out", int'($signed(bus.cordic_out)), 6434 - 8, 6434 + 8);
        chk("vec_err", 32'(bus.err), 0);
`else
        chk("vec_lat", 32'(lat), 1);
        chk("vec_out", 32'(bus.cordic_out), 0);
        chk("vec_err", 32'(bus.err), 1);
`endif
        take("vec");

        // back-pressure: result held, new request ignored
        send(4'b0001, 16'd4289, 16'd0, 16'd0);
        wait_out(lat);
        chk_rng("stall_out", int'($signed(bus.cordic_out)), 8168 - 32, 8168 + 32);
        held = bus.cordic_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.select   = 4'b0010;
            bus.angle_in = 16'd0;
            @(posedge clk);
            #1;
            chk("stall_hold", 32'(bus.cordic_out), 32'(held));
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_out_valid", 32'(bus.out_valid), 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        take("stall");
        chk("stall_idle_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("stall_no_accept", 32'(bus.busy), 0);

        // reset in the middle of iterating
        send(4'b0010, 16'd0, 16'd0, 16'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_out", 32'(bus.cordic_out), 0);
        chk("abort_err", 32'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // cos(0): x settles at 26982 -> 26982*155>>8 = 16336
        send(4'b0010, 16'd0, 16'd0, 16'd0);
        wait_out(lat);
        chk("post_lat", 32'(lat), ITER + 1);
        chk_rng("post_cos0", int'($signed(bus.cordic_out)), 16336 - 2, 16336 + 2);
        chk("post_err", 32'(bus.err), 0);
        take("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
